// File: rtl/barrett_reduce_pipe_pkg.sv
// Barrett reducer shared helpers: constant derivation, width helper, parameter legality check.
// Latency: n/a (package, elaboration-time functions only).
// Backpressure: n/a.
package barrett_pkg;

  // Ceiling log2 for sizing counters/fields from a count.
  function automatic int clog2(input longint v);
    int     n;
    longint p;
    n = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      n = n + 1;
    end
    return n;
  endfunction

  // Barrett constant: floor(2^(2k) / q).
  function automatic longint barrett_mu(input longint q, input int k);
    return (longint'(1) << (2 * k)) / q;
  endfunction

  // Legal configuration: odd q, 3 <= q, q has exactly qw bits, raw operand fits in 2*qw.
  function automatic bit barrett_params_ok(input longint q, input int qw, input int dw);
    return (q >= 3) && ((q % 2) == 1) &&
           (q >= (longint'(1) << (qw - 1))) && (q < (longint'(1) << qw)) &&
           (dw >= 1) && (dw <= 2 * qw);
  endfunction

endpackage

// File: rtl/barrett_cond_sub.sv
// Combinational Barrett correction: maps r < 3Q onto r mod Q with two conditional subtracts.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports r (QW+2 bits, < 3Q) in, y (QW bits, < Q) out.
module barrett_cond_sub
  import barrett_pkg::*;
#(
  parameter int Q  = 2551,
  parameter int QW = 12
) (
  input  logic [QW+1:0] r,
  output logic [QW-1:0] y
);

  localparam int            RW = QW + 2;
  localparam logic [RW-1:0] Q1 = RW'(Q);
  localparam logic [RW-1:0] Q2 = RW'(2 * Q);

  // The quotient estimate can undershoot by up to 2, so both subtract levels are needed.
  always_comb begin
    if (r >= Q2) begin
      y = QW'(r - Q2);
    end else if (r >= Q1) begin
      y = QW'(r - Q1);
    end else begin
      y = QW'(r);
    end
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Pipelined Barrett reducer x mod Q, x = in_a*in_b (in_mul=1) or zero-extended in_x; tag rides along.
// Latency: 4 register stages (S1 operand, S2 quotient, S3 remainder, S4 corrected output), 1 result/cycle.
// Backpressure: global enable adv = !out_valid || out_ready; in_ready = adv && rst_n (combinational from out_ready).
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int Q     = 2551,
  parameter int QW    = 12,
  parameter int DW    = 2 * QW - 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mul,
  input  logic [DW-1:0]    in_x,
  input  logic [QW-1:0]    in_a,
  input  logic [QW-1:0]    in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    out_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int          K   = QW;
  localparam int          XW  = 2 * QW;      // operand width
  localparam int          RW  = QW + 2;      // remainder width, holds values < 3Q
  localparam int          QHW = 2 * QW + 2;  // full (x>>K)*MU product width
  localparam logic [QW:0] MU  = (QW + 1)'(barrett_mu(Q, K));

  if (!barrett_params_ok(Q, QW, DW)) begin : g_param_check
    $error("barrett_reduce_pipe: Q/QW/DW combination is not supported");
  end

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [XW-1:0]    x;
  } s1_t;

  // Only the low RW bits of x matter from here on: r = x - t*Q is taken modulo 2^RW.
  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [RW-1:0]    x;
    logic [RW-1:0]    t;
  } s2_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [RW-1:0]    r;
  } s3_t;

  s1_t           s1;
  s2_t           s2;
  s3_t           s3;
  logic          s4_vld;
  logic          adv;
  logic [XW-1:0] x_in;
  logic [RW-1:0] t_next;
  logic [RW-1:0] r_next;
  logic [QW-1:0] r4_next;

  assign adv       = !s4_vld || out_ready;
  assign in_ready  = adv && rst_n;
  assign out_valid = s4_vld;

  assign x_in = in_mul ? (XW'(in_a) * XW'(in_b)) : XW'(in_x);

  // Quotient estimate t = ((x >> K) * MU) >> K; the product is kept at full width.
  assign t_next = RW'((QHW'(s1.x[XW-1:K]) * QHW'(MU)) >> K);

  // True remainder is < 3Q < 2^RW, so wrapping arithmetic at RW bits is exact.
  assign r_next = s2.x - s2.t * RW'(Q);

  barrett_cond_sub #(
    .Q  (Q),
    .QW (QW)
  ) u_cond_sub (
    .r (s3.r),
    .y (r4_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      s4_vld  <= 1'b0;
      out_r   <= '0;
      out_tag <= '0;
    end else if (adv) begin
      s1.vld  <= in_valid && in_ready;
      s1.tag  <= in_tag;
      s1.x    <= x_in;

      s2.vld  <= s1.vld;
      s2.tag  <= s1.tag;
      s2.x    <= s1.x[RW-1:0];
      s2.t    <= t_next;

      s3.vld  <= s2.vld;
      s3.tag  <= s2.tag;
      s3.r    <= r_next;

      // Bubbles clear the visible output so stale results never linger on the bus.
      s4_vld  <= s3.vld;
      out_r   <= s3.vld ? r4_next : '0;
      out_tag <= s3.vld ? s3.tag : '0;
    end
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
module tb_barrett_reduce_pipe;

  localparam int Q     = 2551;
  localparam int QW    = 12;
  localparam int DW    = 23;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_mul;
  logic [DW-1:0]    in_x;
  logic [QW-1:0]    in_a;
  logic [QW-1:0]    in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [QW-1:0]    out_r;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  barrett_reduce_pipe #(
    .Q     (Q),
    .QW    (QW),
    .DW    (DW),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mul    (in_mul),
    .in_x      (in_x),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_tag   (out_tag)
  );

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int out_cnt = 0;
  bit exact_mode = 1'b0;

  typedef struct {
    int     tag;
    longint r;
    int     acc;
    bit     exact;
  } exp_t;
  exp_t q[$];

  bit               hold = 1'b0;
  logic [QW-1:0]    hold_r;
  logic [TAG_W-1:0] hold_tag;

  // Reference: the mathematical definition of the result.
  function automatic longint golden(input bit mul, input longint a, input longint b, input longint x);
    return mul ? ((a * b) % Q) : (x % Q);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Single compare process: tracks accepted operands in order and checks every output transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold = 1'b0;
      check("in_ready_during_reset", in_ready, 0);
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_r", out_r, hold_r);
        check("stall_tag", out_tag, hold_tag);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_output: got r=%0d tag=%0d, expected no result", out_r, out_tag);
        end else begin
          e = q.pop_front();
          check("out_r", out_r, e.r);
          check("out_tag", out_tag, e.tag);
          if (e.exact) check("latency", cyc - e.acc, 4);
          else         check("latency_min", (cyc - e.acc) >= 4, 1);
          out_cnt++;
        end
      end
      if (in_valid && in_ready)
        q.push_back('{int'(in_tag), golden(in_mul, in_a, in_b, in_x), cyc, exact_mode});
      hold     = out_valid && !out_ready;
      hold_r   = out_r;
      hold_tag = out_tag;
    end
  end

  // Present one operand and hold it until accepted (called at posedge+1, returns at posedge+1).
  task automatic send(input bit mul, input int a, input int b, input int x, input int tag);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_mul   = mul;
    in_a     = QW'(a);
    in_b     = QW'(b);
    in_x     = DW'(x);
    in_tag   = TAG_W'(tag);
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no acceptance in %0d cycles, expected acceptance", n);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc;
    int base;
    int sent;
    int tagc;
    int guard;
    bit acc_last;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_mul    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_x      = '0;
    in_tag    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_r", out_r, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Hand-computed values pin the model
    check("model_raw_max", golden(0, 0, 0, 8388607), 919);
    check("model_raw_q", golden(0, 0, 0, 2551), 0);
    check("model_sq", golden(1, 2550, 2550, 0), 1);
    check("model_5103", golden(0, 0, 0, 5103), 1);
    check("model_mul_id", golden(1, 1234, 1, 0), 1234);

    // Back-to-back, no stalls: exact 4-cycle latency, consecutive results
    exact_mode = 1'b1;
    send(0, 0, 0, 0, 1);
    send(0, 0, 0, 2550, 2);
    send(0, 0, 0, 2551, 3);
    send(0, 0, 0, 8388607, 4);
    send(1, 2550, 2550, 0, 5);
    send(1, 1234, 1, 0, 6);
    send(1, 0, 2550, 0, 7);
    drain();
    exact_mode = 1'b0;

    // Backpressure: only 4 fit while the output is stalled
    out_ready = 1'b0;
    acc = 0;
    base = out_cnt;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_mul   = 1'b0;
      in_x     = DW'($urandom);
      in_tag   = TAG_W'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 4);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid_high", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int t = 4; t < 6; t++) send(0, 0, 0, int'($urandom_range(0, 8388607)), t);
    drain();
    check("bp_out_count", out_cnt - base, 6);

    // Reset with 3 operands in flight and S4 stalled
    out_ready = 1'b0;
    send(0, 0, 0, 100, 8);
    send(1, 77, 99, 0, 9);
    send(0, 0, 0, 4000000, 10);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_flush_valid", out_valid, 0);
    check("rst_flush_r", out_r, 0);
    check("rst_flush_tag", out_tag, 0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    out_ready  = 1'b1;
    exact_mode = 1'b1;
    base = out_cnt;
    send(0, 0, 0, 5103, 11);
    drain();
    exact_mode = 1'b0;
    check("rst_one_result", out_cnt - base, 1);

    // Boundaries around multiples of Q and the top of the raw range
    for (int k = 1; k < 3289; k += 37) begin
      send(0, 0, 0, k * Q - 1, k);
      send(0, 0, 0, k * Q, k + 1);
      if (k * Q + 1 < 8388608) send(0, 0, 0, k * Q + 1, k + 2);
    end
    for (int d = 0; d < 20; d++) send(0, 0, 0, 8388607 - d, d);
    send(1, 4095, 4095, 0, 1);
    send(1, 4095, Q - 1, 0, 2);
    send(1, Q - 1, 1, 0, 3);
    drain();

    // Randomized traffic with random stalls on both sides
    sent = 0;
    tagc = 0;
    guard = 0;
    acc_last = 1'b0;
    in_valid = 1'b0;
    while (sent < 15000 && guard < 60000) begin
      if (!in_valid || acc_last) begin
        in_valid = (($urandom % 10) < 7);
        in_mul   = $urandom % 2;
        in_a     = (($urandom % 8) == 0) ? QW'($urandom % 4096) : QW'($urandom_range(0, Q - 1));
        in_b     = (($urandom % 8) == 0) ? QW'($urandom % 4096) : QW'($urandom_range(0, Q - 1));
        in_x     = DW'($urandom);
        in_tag   = TAG_W'(tagc);
      end
      out_ready = (($urandom % 10) < 7);
      @(negedge clk);
      acc_last = in_valid && in_ready;
      if (acc_last) begin
        sent++;
        tagc++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    check("random_all_sent", sent, 15000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
